// File: rtl/inst_cache_if.sv
// inst_cache_if: bundles the IF-side and mem_ctrl-side signals of the
// instruction cache.
//   slave  : cache side (drives if_inst/if_rdy/if_busy/inst_needed/inst_addr)
//   master : environment side (IF stage, MEM stage arbitration, mem_ctrl)
interface inst_cache_if #(
  parameter int ADDR_W = 32
);
  logic              is_jump;
  logic              if_req;
  logic [ADDR_W-1:0] if_pc;
  logic [31:0]       if_inst;
  logic              if_rdy;
  logic              if_busy;
  logic              mem_needed;
  logic              inst_needed;
  logic [ADDR_W-1:0] inst_addr;
  logic [31:0]       inst_data;
  logic              inst_rdy;

  modport slave (
    input  is_jump, if_req, if_pc, mem_needed, inst_data, inst_rdy,
    output if_inst, if_rdy, if_busy, inst_needed, inst_addr
  );

  modport master (
    output is_jump, if_req, if_pc, mem_needed, inst_data, inst_rdy,
    input  if_inst, if_rdy, if_busy, inst_needed, inst_addr
  );
endinterface

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped, one-word-per-line, read-only instruction cache
// between the IF stage and mem_ctrl. Hits answer one cycle after the request;
// misses fetch through mem_ctrl (yielding to MEM traffic) and answer one cycle
// after inst_rdy. is_jump aborts any outstanding fetch.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : inst_cache_if.slave (IF request/response, mem_ctrl fetch)
//
// state     | meaning
// ----------+----------------------------------------------
// IDLE      | accepting IF requests, hits answered directly
// WAIT_PORT | miss pending, MEM stage owns the RAM port
// MISS      | inst_needed asserted, waiting for inst_rdy
module inst_cache #(
  parameter int INDEX_BITS = 7,
  parameter int ADDR_W     = 32
) (
  input  logic          clk,
  input  logic          rst,
  inst_cache_if.slave   bus
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, WAIT_PORT, MISS} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-3:0]   req_word_q, req_word_d;
  logic [31:0]         if_inst_q, if_inst_d;
  logic                if_rdy_q, if_rdy_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [31:0]         data_q [LINES];
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic                fill_en;

  logic [INDEX_BITS-1:0] pc_idx, req_idx;
  logic [TAG_W-1:0]      pc_tag, req_tag;
  logic                  hit;
  logic                  unused_pc_bits;

  assign pc_idx  = bus.if_pc[INDEX_BITS+1:2];
  assign pc_tag  = bus.if_pc[ADDR_W-1:INDEX_BITS+2];
  assign req_idx = req_word_q[INDEX_BITS-1:0];
  assign req_tag = req_word_q[ADDR_W-3:INDEX_BITS];
  assign hit     = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  // Fetches are word aligned; the byte offset plays no part in lookup.
  assign unused_pc_bits = ^bus.if_pc[1:0];

  always_comb begin
    state_d    = state_q;
    req_word_d = req_word_q;
    if_inst_d  = if_inst_q;
    if_rdy_d   = 1'b0;
    valid_d    = valid_q;
    fill_en    = 1'b0;
    if (bus.is_jump) begin
      // Redirect wins over everything: no response, no fill, even if
      // inst_rdy arrives in this same cycle.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.if_req) begin
            if (hit) begin
              if_rdy_d  = 1'b1;
              if_inst_d = data_q[pc_idx];
            end else begin
              req_word_d = bus.if_pc[ADDR_W-1:2];
              state_d    = bus.mem_needed ? WAIT_PORT : MISS;
            end
          end
        end
        WAIT_PORT: begin
          if (!bus.mem_needed) state_d = MISS;
        end
        MISS: begin
          if (bus.inst_rdy) begin
            fill_en          = 1'b1;
            valid_d[req_idx] = 1'b1;
            if_rdy_d         = 1'b1;
            if_inst_d        = bus.inst_data;
            state_d          = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_word_q <= '0;
      if_inst_q  <= '0;
      if_rdy_q   <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_word_q <= req_word_d;
      if_inst_q  <= if_inst_d;
      if_rdy_q   <= if_rdy_d;
      valid_q    <= valid_d;
    end
  end

  // Line payloads need no reset; valid_q guards them.
  always_ff @(posedge clk) begin
    if (!rst && fill_en) begin
      data_q[req_idx] <= bus.inst_data;
      tag_q[req_idx]  <= req_tag;
    end
  end

  assign bus.if_inst     = if_inst_q;
  assign bus.if_rdy      = if_rdy_q;
  assign bus.if_busy     = (state_q != IDLE);
  assign bus.inst_needed = (state_q == MISS);
  assign bus.inst_addr   = {req_word_q, 2'b00};
endmodule

// File: tb/tb_inst_cache.sv
module tb_inst_cache;
  localparam int INDEX_BITS = 7;
  localparam int ADDR_W     = 32;
  localparam int LINES      = 1 << INDEX_BITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  // Reference model: which word address each line currently holds.
  bit        m_valid [LINES];
  bit [29:0] m_word  [LINES];
  logic [31:0] exp_inst;

  inst_cache_if #(.ADDR_W(ADDR_W)) bus ();

  inst_cache #(.INDEX_BITS(INDEX_BITS), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h10) return 32'h00A00093;
    return w * 32'h9E3779B1 + 32'h12345677;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  // One fetch: predicted hit or miss from the model. hold = cycles mem_needed
  // stays high starting with the request cycle, lat = cycles inst_needed is
  // seen before inst_rdy is returned (inst_rdy on the lat-th), jump = abort
  // with is_jump coincident with inst_rdy.
  task automatic fetch(input logic [31:0] pc, input int hold, input int lat, input bit jump);
    int   idx;
    bit   exp_hit;
    logic [31:0] word_addr;
    idx       = int'((pc >> 2) % LINES);
    word_addr = {pc[31:2], 2'b00};
    exp_hit   = m_valid[idx] && (m_word[idx] == pc[31:2]);
    bus.if_req     = 1'b1;
    bus.if_pc      = pc;
    bus.mem_needed = exp_hit ? 1'b0 : (hold > 0);
    if (exp_hit) begin
      @(negedge clk);
      bus.if_req = 1'b0;
      chk("hit_rdy", 32'(bus.if_rdy), 32'd1);
      chk("hit_inst", bus.if_inst, mem_word(pc));
      chk("hit_no_fetch", 32'(bus.inst_needed), 32'd0);
      exp_inst = mem_word(pc);
      @(negedge clk);
      chk("hit_pulse", 32'(bus.if_rdy), 32'd0);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.if_req = 1'b0;
      chk("yield_needed", 32'(bus.inst_needed), 32'd0);
      chk("yield_busy", 32'(bus.if_busy), 32'd1);
      if (i == hold - 1) bus.mem_needed = 1'b0;
    end
    @(negedge clk);
    bus.if_req = 1'b0;
    for (int j = 0; j < lat; j++) begin
      chk("miss_needed", 32'(bus.inst_needed), 32'd1);
      chk("miss_addr", bus.inst_addr, word_addr);
      chk("miss_rdy_low", 32'(bus.if_rdy), 32'd0);
      if (j == lat - 1) begin
        bus.inst_rdy  = 1'b1;
        bus.inst_data = mem_word(pc);
        bus.is_jump   = jump;
      end
      @(negedge clk);
    end
    bus.inst_rdy = 1'b0;
    bus.is_jump  = 1'b0;
    chk("fill_needed_drop", 32'(bus.inst_needed), 32'd0);
    chk("fill_busy_drop", 32'(bus.if_busy), 32'd0);
    if (jump) begin
      chk("jump_no_rdy", 32'(bus.if_rdy), 32'd0);
    end else begin
      chk("fill_rdy", 32'(bus.if_rdy), 32'd1);
      exp_inst     = mem_word(pc);
      m_valid[idx] = 1'b1;
      m_word[idx]  = pc[31:2];
    end
    chk("fill_inst", bus.if_inst, exp_inst);
    @(negedge clk);
    chk("rdy_pulse", 32'(bus.if_rdy), 32'd0);
    chk("inst_hold", bus.if_inst, exp_inst);
  endtask

  initial begin
    logic [31:0] pc;
    bus.is_jump    = 1'b0;
    bus.if_req     = 1'b0;
    bus.if_pc      = '0;
    bus.mem_needed = 1'b0;
    bus.inst_data  = '0;
    bus.inst_rdy   = 1'b0;
    clear_model();
    exp_inst = '0;
    repeat (3) @(negedge clk);
    chk("rst_inst", bus.if_inst, 32'd0);
    chk("rst_rdy", 32'(bus.if_rdy), 32'd0);
    chk("rst_busy", 32'(bus.if_busy), 32'd0);
    chk("rst_needed", 32'(bus.inst_needed), 32'd0);
    chk("rst_addr", bus.inst_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss, then repeat hit.
    fetch(32'h10, 0, 4, 1'b0);
    fetch(32'h10, 0, 1, 1'b0);

    // Back-to-back hits: one result per cycle.
    bus.if_req = 1'b1;
    bus.if_pc  = 32'h10;
    @(negedge clk);
    chk("b2b_rdy0", 32'(bus.if_rdy), 32'd1);
    chk("b2b_inst0", bus.if_inst, 32'h00A00093);
    @(negedge clk);
    bus.if_req = 1'b0;
    chk("b2b_rdy1", 32'(bus.if_rdy), 32'd1);
    chk("b2b_inst1", bus.if_inst, 32'h00A00093);
    chk("b2b_needed", 32'(bus.inst_needed), 32'd0);
    @(negedge clk);
    chk("b2b_pulse", 32'(bus.if_rdy), 32'd0);

    // Conflict eviction: 0x210 shares index with 0x10.
    fetch(32'h210, 0, 2, 1'b0);
    fetch(32'h10, 0, 2, 1'b0);

    // Port yield for 5 cycles.
    fetch(32'h84, 5, 3, 1'b0);

    // Jump coincident with inst_rdy: no fill, refetch misses again.
    fetch(32'h100, 0, 3, 1'b1);
    fetch(32'h100, 0, 2, 1'b0);

    // Hit request in the is_jump cycle produces no response.
    bus.if_req  = 1'b1;
    bus.if_pc   = 32'h10;
    bus.is_jump = 1'b1;
    @(negedge clk);
    bus.if_req  = 1'b0;
    bus.is_jump = 1'b0;
    chk("jump_hit_rdy", 32'(bus.if_rdy), 32'd0);
    chk("jump_hit_busy", 32'(bus.if_busy), 32'd0);

    // Reset mid-miss: outputs clear and every line misses afterwards.
    bus.if_req = 1'b1;
    bus.if_pc  = 32'h400;
    @(negedge clk);
    bus.if_req = 1'b0;
    chk("rmiss_needed", 32'(bus.inst_needed), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    exp_inst = '0;
    chk("rmiss_inst", bus.if_inst, 32'd0);
    chk("rmiss_rdy", 32'(bus.if_rdy), 32'd0);
    chk("rmiss_busy", 32'(bus.if_busy), 32'd0);
    chk("rmiss_needed0", 32'(bus.inst_needed), 32'd0);
    chk("rmiss_addr", bus.inst_addr, 32'd0);
    fetch(32'h10, 0, 1, 1'b0);
    fetch(32'h84, 0, 1, 1'b0);

    // Random traffic over a few conflicting lines.
    for (int n = 0; n < 60; n++) begin
      pc = ($urandom_range(0, 2) << 9) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      fetch(pc, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
            int'($urandom_range(1, 4)), $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped, one-word-per-line, read-only instruction cache between the IF stage and mem_ctrl.
- Returns hits one cycle after the request.
- On a miss, drives inst_needed/inst_addr to mem_ctrl, waits for inst_rdy, fills the line, then answers IF.
- Yields the RAM port to pending load/store traffic.
- Aborts in-flight fetches on is_jump.

Parameters:
- INDEX_BITS, 7, number of index bits; 2^INDEX_BITS lines.
- ADDR_W, 32, instruction address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- is_jump  in  1  pipeline redirect; cancels the outstanding fetch.
- if_req  in  1  IF requests an instruction at if_pc.
- if_pc  in  ADDR_W  fetch address; word aligned, bits [1:0] ignored.
- if_inst  out  32  instruction returned to IF.
- if_rdy  out  1  one-cycle pulse; if_inst is valid.
- if_busy  out  1  a miss is outstanding.
- mem_needed  in  1  MEM stage holds the RAM port; inhibits new miss requests.
- inst_needed  out  1  fetch request to mem_ctrl.
- inst_addr  out  ADDR_W  fetch address to mem_ctrl.
- inst_data  in  32  fetched word from mem_ctrl.
- inst_rdy  in  1  mem_ctrl fetch complete; inst_data valid this cycle.

Behaviour:
- Address split:
  - index = if_pc[INDEX_BITS+1:2]
  - tag = if_pc[ADDR_W-1:INDEX_BITS+2]
- Storage: data[2^INDEX_BITS] x 32, tag[2^INDEX_BITS] x (ADDR_W-INDEX_BITS-2), valid[2^INDEX_BITS] as a flat register vector.
- Reset: valid all 0; if_inst=0, if_rdy=0, if_busy=0, inst_needed=0, inst_addr=0; state=IDLE. Reset mid-miss discards the miss and drops inst_needed the next cycle.
- States: IDLE, WAIT_PORT, MISS.
- IDLE, if_req=1, hit (valid[index] and tag match):
  - next cycle if_rdy=1, if_inst=data[index].
  - Stay IDLE; back-to-back hits give one result per cycle.
- IDLE, if_req=1, miss:
  - Latch req_addr=if_pc.
  - If mem_needed=0: go MISS; next cycle inst_needed=1, inst_addr=req_addr.
  - Else go WAIT_PORT; if_busy=1 in both cases.
- WAIT_PORT: inst_needed=0. When mem_needed=0, go MISS and assert inst_needed.
- MISS:
  - Hold inst_needed=1 and inst_addr stable until inst_rdy=1.
  - On inst_rdy: write data/tag/valid at req_addr's index, drop inst_needed, and next cycle if_rdy=1, if_inst=inst_data, if_busy=0. Go IDLE.
  - Total miss latency = mem_ctrl latency + 1 cycle.
- if_req while if_busy=1 is ignored; IF holds the request and re-presents it.
- is_jump, any state:
  - Next cycle state=IDLE, inst_needed=0, if_busy=0, if_rdy=0; no fill.
  - inst_rdy in the same cycle as is_jump is discarded; the line is not written.
  - A hit request in the is_jump cycle produces no if_rdy.
  - is_jump has priority over everything except rst.
- if_rdy is a single-cycle pulse, 0 in every cycle not listed above. if_inst holds its last value otherwise.
- Replacement: direct-mapped overwrite. A fill to an index holding a different tag evicts it.
- No writes from MEM are snooped; self-modifying code is unsupported.

Test Plan:
- Cold miss:
  - Stimulus: after reset, if_req pc=0x00000010; mem_ctrl returns 0x00A00093 four cycles after inst_needed.
  - Required: inst_needed=1 with inst_addr=0x10 held until inst_rdy; if_rdy=1, if_inst=0x00A00093 one cycle after inst_rdy; if_busy 1→0.
- Hit after fill:
  - Stimulus: re-request pc=0x10, then pc=0x10 again back-to-back.
  - Required: if_rdy on each following cycle with 0x00A00093; inst_needed stays 0.
- Conflict eviction (INDEX_BITS=7):
  - Stimulus: fill 0x10, then fetch 0x210.
  - Required: a miss is issued for 0x210. A subsequent 0x10 fetch misses again.
- Port yield:
  - Stimulus: miss while mem_needed=1 for 5 cycles.
  - Required: inst_needed=0 for those cycles, asserted the cycle after mem_needed falls.
- Jump mid-miss:
  - Stimulus: is_jump pulses while in MISS, coincident with inst_rdy.
  - Required: no if_rdy; inst_needed=0 next cycle; refetching the same pc misses again because the line was not filled.
- Reset mid-miss:
  - Stimulus: rst during MISS.
  - Required: all outputs 0 next cycle; all previously filled lines miss.
